// File: rtl/issue_queue_mem_mp_pkg.sv
// Shared types and sizing for the multi-port memory issue queue.
// Width macros may be overridden on the command line; defaults follow.
`ifndef PRF_INT_INDEX_SIZE
`define PRF_INT_INDEX_SIZE 6
`endif
`ifndef IQ_MEM_SIZE
`define IQ_MEM_SIZE 16
`endif
`ifndef ISSUE_WIDTH_MEM
`define ISSUE_WIDTH_MEM 2
`endif
`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

package issue_queue_mem_mp_pkg;
    localparam int IQ_PRF_IDX_W  = `PRF_INT_INDEX_SIZE;
    localparam int IQ_DEPTH      = `IQ_MEM_SIZE;
    localparam int IQ_ISSUE_W    = `ISSUE_WIDTH_MEM;
    localparam int IQ_DISPATCH_W = `DISPATCH_WIDTH;

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        RS_FROM_RF   = 2'd0,
        RS_FROM_IMM  = 2'd1,
        RS_FROM_PC   = 2'd2,
        RS_FROM_ZERO = 2'd3
    } rs_src_e;

    typedef struct packed {
        logic                    valid;
        mem_op_e                 mem_op;
        rs_src_e                 rs1_src;
        logic [IQ_PRF_IDX_W-1:0] rs1;
        rs_src_e                 rs2_src;
        logic [IQ_PRF_IDX_W-1:0] rs2;
        logic [IQ_PRF_IDX_W-1:0] prd;
        logic [7:0]              tag;
    } micro_op_t;

    // Per-slot next-state source chosen by the top-level compaction logic.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_SHIFT = 2'd1,
        SLOT_LOAD  = 2'd2
    } slot_sel_e;

    localparam micro_op_t UOP_NONE = '0;
endpackage

// File: rtl/issue_queue_mem_mp_slot.sv
// One issue-queue slot: entry register, shift-in/load mux, source index
// generation and readiness.
module iq_mem_slot
    import issue_queue_mem_mp_pkg::*;
#(
    parameter int PRF_IDX_W = IQ_PRF_IDX_W
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  slot_sel_e            i_sel,
    input  micro_op_t            i_shift_uop,
    input  micro_op_t            i_load_uop,
    input  logic                 i_rs1_busy,
    input  logic                 i_rs2_busy,
    output micro_op_t            o_uop,
    output logic [PRF_IDX_W-1:0] o_rs1_index,
    output logic [PRF_IDX_W-1:0] o_rs2_index,
    output logic                 o_ready,
    output logic                 o_free
);
    micro_op_t r_uop;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_uop <= UOP_NONE;
        end else begin
            case (i_sel)
                SLOT_SHIFT: r_uop <= i_shift_uop;
                SLOT_LOAD:  r_uop <= i_load_uop;
                default:    r_uop <= UOP_NONE;
            endcase
        end
    end

    // Only register-file sources reach the busy table; everything else reads index 0.
    assign o_rs1_index = (r_uop.valid && (r_uop.rs1_src == RS_FROM_RF)) ? r_uop.rs1 : '0;
    assign o_rs2_index = (r_uop.valid && (r_uop.rs2_src == RS_FROM_RF)) ? r_uop.rs2 : '0;
    assign o_ready     = r_uop.valid && !i_rs1_busy && !i_rs2_busy;
    assign o_free      = !r_uop.valid;
    assign o_uop       = r_uop;
endmodule

// File: rtl/issue_queue_mem_mp.sv
// Age-ordered compacting memory issue queue, DISPATCH_W in / ISSUE_W out.
// IQ_MEM_LOAD_BYPASS_EN lets loads issue past older stores.
module issue_queue_mem_mp
    import issue_queue_mem_mp_pkg::*;
#(
    parameter int DEPTH      = IQ_DEPTH,
    parameter int DISPATCH_W = IQ_DISPATCH_W,
    parameter int ISSUE_W    = IQ_ISSUE_W,
    parameter int PRF_IDX_W  = IQ_PRF_IDX_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_en,
    input  logic                   load_en,
    input  micro_op_t              uop_in    [DISPATCH_W],
    output logic [PRF_IDX_W-1:0]   rs1_index [DEPTH],
    output logic [PRF_IDX_W-1:0]   rs2_index [DEPTH],
    input  logic [DEPTH-1:0]       rs1_busy,
    input  logic [DEPTH-1:0]       rs2_busy,
    input  logic [ISSUE_W-1:0]     ex_busy,
    output micro_op_t              uop_out   [ISSUE_W],
    output logic                   iq_mem_full,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: dispatch lanes are taken when load_en=1 and lane.valid=1, and
    // only while iq_mem_full=0; an issue port takes uop_out[p] when its valid=1
    // and ex_busy[p]=0 in the same cycle, with no further acknowledge.

    logic [CW-1:0] r_occupancy;
    logic          r_full;

    micro_op_t  w_slot_uop  [DEPTH];
    micro_op_t  w_shift_uop [DEPTH];
    micro_op_t  w_load_uop  [DEPTH];
    slot_sel_e  w_sel       [DEPTH];
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_is_st;
    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_issue;
    logic [DEPTH-1:0] w_survive;
    logic [CW-1:0]    w_elig_rank [DEPTH];
    logic [CW-1:0]    w_surv_rank [DEPTH];
    logic [CW-1:0]    w_port_rank [ISSUE_W];
    logic [CW-1:0]    w_lane_rank [DISPATCH_W];
    logic [CW-1:0]    w_num_free;
    logic [CW-1:0]    w_num_surv;
    logic [CW-1:0]    w_num_new;
    logic [CW-1:0]    w_free_slots;
    logic [CW-1:0]    w_accepted;
    logic [CW-1:0]    w_occ_next;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        iq_mem_slot #(
            .PRF_IDX_W (PRF_IDX_W)
        ) u_slot (
            .i_clock     (clock),
            .i_reset     (reset),
            .i_clear     (clear_en),
            .i_sel       (w_sel[g]),
            .i_shift_uop (w_shift_uop[g]),
            .i_load_uop  (w_load_uop[g]),
            .i_rs1_busy  (rs1_busy[g]),
            .i_rs2_busy  (rs2_busy[g]),
            .o_uop       (w_slot_uop[g]),
            .o_rs1_index (rs1_index[g]),
            .o_rs2_index (rs2_index[g]),
            .o_ready     (w_ready[g]),
            .o_free      (w_free[g])
        );
        assign w_valid[g] = !w_free[g];
        assign w_is_st[g] = (w_slot_uop[g].mem_op == MEM_ST);
    end

    // Prefix counts: free-port rank, eligible rank, survivor rank, lane rank.
    always_comb begin
        logic          seen_st;
        logic [CW-1:0] f_cnt;
        logic [CW-1:0] e_cnt;
        logic [CW-1:0] s_cnt;
        logic [CW-1:0] l_cnt;
        seen_st   = 1'b0;
        f_cnt     = '0;
        e_cnt     = '0;
        s_cnt     = '0;
        l_cnt     = '0;
        w_elig    = '0;
        w_issue   = '0;
        w_survive = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            w_port_rank[p] = f_cnt;
            if (!ex_busy[p]) f_cnt = f_cnt + CW'(1);
        end
        w_num_free = f_cnt;
        for (int k = 0; k < DEPTH; k++) begin
            w_elig_rank[k] = e_cnt;
            w_surv_rank[k] = s_cnt;
            if (w_is_st[k]) begin
                w_elig[k] = w_ready[k] && (k == 0);
            end else begin
`ifdef IQ_MEM_LOAD_BYPASS_EN
                w_elig[k] = w_ready[k];
`else
                w_elig[k] = w_ready[k] && !seen_st;
`endif
            end
            w_issue[k]   = w_elig[k] && (e_cnt < w_num_free);
            w_survive[k] = w_valid[k] && !w_issue[k];
            if (w_elig[k])    e_cnt = e_cnt + CW'(1);
            if (w_survive[k]) s_cnt = s_cnt + CW'(1);
            seen_st = seen_st || (w_valid[k] && w_is_st[k]);
        end
        w_num_surv = s_cnt;
        for (int l = 0; l < DISPATCH_W; l++) begin
            w_lane_rank[l] = l_cnt;
            if (load_en && uop_in[l].valid) l_cnt = l_cnt + CW'(1);
        end
        w_num_new = l_cnt;
    end

    // The n-th selected entry goes to the n-th free port.
    always_comb begin
        for (int p = 0; p < ISSUE_W; p++) begin
            uop_out[p] = UOP_NONE;
            if (!ex_busy[p]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (w_issue[k] && (w_elig_rank[k] == w_port_rank[p])) begin
                        uop_out[p] = w_slot_uop[k];
                    end
                end
            end
            if (clear_en) uop_out[p].valid = 1'b0;
        end
    end

    // Survivors close gaps; new lanes append after them and overflow is dropped.
    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            w_shift_uop[d] = UOP_NONE;
            w_load_uop[d]  = UOP_NONE;
            w_sel[d]       = SLOT_EMPTY;
            for (int j = 0; j < DEPTH; j++) begin
                if (w_survive[j] && (w_surv_rank[j] == CW'(d))) begin
                    w_shift_uop[d] = w_slot_uop[j];
                    w_sel[d]       = SLOT_SHIFT;
                end
            end
            for (int l = 0; l < DISPATCH_W; l++) begin
                if (load_en && uop_in[l].valid && ((w_num_surv + w_lane_rank[l]) == CW'(d))) begin
                    w_load_uop[d] = uop_in[l];
                    w_sel[d]      = SLOT_LOAD;
                end
            end
        end
    end

    assign w_free_slots = CW'(DEPTH) - w_num_surv;
    assign w_accepted   = (w_num_new > w_free_slots) ? w_free_slots : w_num_new;
    assign w_occ_next   = w_num_surv + w_accepted;

    always_ff @(posedge clock) begin
        if (reset || clear_en) begin
            r_occupancy <= '0;
            r_full      <= 1'b0;
        end else begin
            r_occupancy <= w_occ_next;
            r_full      <= (CW'(DEPTH) - w_occ_next) < CW'(DISPATCH_W);
        end
    end

    assign occupancy   = r_occupancy;
    assign iq_mem_full = r_full;

    a_no_dispatch_when_full: assert property (
        @(posedge clock) disable iff (reset || clear_en) !(load_en && r_full)
    );
endmodule
